// File: rtl/ninjin_ddr_linebuf.sv
// Line buffer between the word-wide ninjin memory port and a wide DDR bus: one read line,
// one write-combining line with lane strobes, flush/auto-flush and ready/valid DDR requests.
module ninjin_ddr_linebuf #(
  parameter int DWIDTH  = 16,
  parameter int BWIDTH  = 64,
  parameter int MEMSIZE = 12,
  parameter int LWIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         xrst,
  input  logic [LWIDTH-1:0]            total_len,
  input  logic                         flush,
  input  logic                         mem_req,
  input  logic                         mem_we,
  input  logic [MEMSIZE-1:0]           mem_addr,
  input  logic signed [DWIDTH-1:0]     mem_wdata,
  output logic signed [DWIDTH-1:0]     mem_rdata,
  output logic                         mem_stall,
  output logic                         done,
  input  logic                         ddr_ready,
  input  logic                         ddr_rvalid,
  input  logic [BWIDTH-1:0]            ddr_rdata,
  output logic                         ddr_we,
  output logic                         ddr_re,
  output logic [MEMSIZE-1:0]           ddr_addr,
  output logic [BWIDTH-1:0]            ddr_wdata,
  output logic [BWIDTH/DWIDTH-1:0]     ddr_strb
);

  localparam int RATE = BWIDTH / DWIDTH;
  localparam int LB   = $clog2(RATE);
  localparam int TW   = MEMSIZE - LB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WB      = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  function automatic logic [DWIDTH-1:0] lane_sel(input logic [BWIDTH-1:0] line, input logic [LB-1:0] idx);
    lane_sel = line[DWIDTH-1:0];
    for (int i = 0; i < RATE; i++) begin
      lane_sel = (idx == LB'(i)) ? line[i*DWIDTH +: DWIDTH] : lane_sel;
    end
  endfunction

  function automatic logic [BWIDTH-1:0] lane_put(input logic [BWIDTH-1:0] line, input logic [LB-1:0] idx,
                                                 input logic [DWIDTH-1:0] data);
    lane_put = line;
    for (int i = 0; i < RATE; i++) begin
      lane_put[i*DWIDTH +: DWIDTH] = (idx == LB'(i)) ? data : line[i*DWIDTH +: DWIDTH];
    end
  endfunction

  state_t              state_r, state_nx_s;
  logic [BWIDTH-1:0]   wline_r, rline_r;
  logic [RATE-1:0]     wstrb_r;
  logic [TW-1:0]       wtag_r, rtag_r;
  logic                rvalid_r, flush_pend_r, flush_wb_r, rd_after_wb_r, done_r;
  logic [LWIDTH-1:0]   wcnt_r, wcnt_inc_s;
  logic [MEMSIZE-1:0]  ddr_addr_r;
  logic [DWIDTH-1:0]   rdata_r;

  logic [TW-1:0]       tag_s;
  logic [LB-1:0]       lane_s;
  logic                wempty_s, wtag_hit_s, fwd_s, rhit_s, miss_s;
  logic                acc_s, acc_wr_s, acc_rd_s, auto_s, flush_any_s, handled_s;
  logic                go_wb_s, go_rd_s, flush_go_s, done_nx_s;

  assign tag_s       = mem_addr[MEMSIZE-1:LB];
  assign lane_s      = mem_addr[LB-1:0];
  assign wempty_s    = (wstrb_r == '0);
  assign wtag_hit_s  = !wempty_s && (wtag_r == tag_s);
  assign fwd_s       = wtag_hit_s && wstrb_r[lane_s];
  assign rhit_s      = rvalid_r && (rtag_r == tag_s);
  assign miss_s      = mem_req && (state_r == ST_IDLE) &&
                       (mem_we ? !(wempty_s || wtag_hit_s) : !(fwd_s || rhit_s));
  assign mem_stall   = (state_r != ST_IDLE) || miss_s;
  assign acc_s       = mem_req && !mem_stall;
  assign acc_wr_s    = acc_s && mem_we;
  assign acc_rd_s    = acc_s && !mem_we;
  assign wcnt_inc_s  = wcnt_r + LWIDTH'(1);
  assign auto_s      = acc_wr_s && (total_len != '0) && (wcnt_inc_s == total_len);
  assign flush_any_s = flush || flush_pend_r;
  assign handled_s   = (state_r == ST_IDLE) && !miss_s;

  assign mem_rdata = $signed(rdata_r);
  assign done      = done_r;
  assign ddr_we    = (state_r == ST_WB);
  assign ddr_re    = (state_r == ST_RD_REQ);
  assign ddr_addr  = ddr_addr_r;
  assign ddr_wdata = ddr_we ? wline_r : '0;
  assign ddr_strb  = ddr_we ? wstrb_r : '0;

  // State register
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state decode; a flush with a same-cycle write sees the merged line as non-empty
  always_comb begin
    state_nx_s = state_r;
    go_wb_s    = 1'b0;
    go_rd_s    = 1'b0;
    flush_go_s = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          if (mem_we || wtag_hit_s) begin
            state_nx_s = ST_WB;
            go_wb_s    = 1'b1;
          end else begin
            state_nx_s = ST_RD_REQ;
            go_rd_s    = 1'b1;
          end
        end else if (flush_any_s || auto_s) begin
          if (!wempty_s || acc_wr_s) begin
            state_nx_s = ST_WB;
            go_wb_s    = 1'b1;
            flush_go_s = 1'b1;
          end else begin
            done_nx_s  = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WB: begin
        if (ddr_ready) begin
          done_nx_s  = flush_wb_r;
          state_nx_s = rd_after_wb_r ? ST_RD_REQ : ST_IDLE;
        end else begin
          state_nx_s = ST_WB;
        end
      end
      ST_RD_REQ: begin
        if (ddr_ready) state_nx_s = ST_RD_WAIT;
        else           state_nx_s = ST_RD_REQ;
      end
      ST_RD_WAIT: begin
        if (ddr_rvalid) state_nx_s = ST_IDLE;
        else            state_nx_s = ST_RD_WAIT;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Line buffers, counters and DDR request address
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wline_r       <= '0;
      wstrb_r       <= '0;
      wtag_r        <= '0;
      rline_r       <= '0;
      rtag_r        <= '0;
      rvalid_r      <= 1'b0;
      wcnt_r        <= '0;
      flush_pend_r  <= 1'b0;
      flush_wb_r    <= 1'b0;
      rd_after_wb_r <= 1'b0;
      ddr_addr_r    <= '0;
      rdata_r       <= '0;
      done_r        <= 1'b0;
    end else begin
      done_r       <= done_nx_s;
      flush_pend_r <= handled_s ? 1'b0 : (flush_pend_r | flush);
      if (acc_wr_s) begin
        wline_r         <= lane_put(wline_r, lane_s, mem_wdata);
        wstrb_r[lane_s] <= 1'b1;
        wtag_r          <= tag_s;
        wcnt_r          <= auto_s ? '0 : wcnt_inc_s;
      end else if (state_r == ST_WB && ddr_ready) begin
        wstrb_r <= '0;
      end
      // Keep the read line coherent with writes to its tag
      if (state_r == ST_RD_WAIT && ddr_rvalid) begin
        rline_r  <= ddr_rdata;
        rtag_r   <= ddr_addr_r[MEMSIZE-1:LB];
        rvalid_r <= 1'b1;
      end else if (acc_wr_s && rhit_s) begin
        rline_r  <= lane_put(rline_r, lane_s, mem_wdata);
      end
      if (acc_rd_s) begin
        rdata_r <= fwd_s ? lane_sel(wline_r, lane_s) : lane_sel(rline_r, lane_s);
      end
      if (go_wb_s) begin
        flush_wb_r    <= flush_go_s;
        rd_after_wb_r <= miss_s && !mem_we;
        ddr_addr_r    <= {(acc_wr_s ? tag_s : wtag_r), {LB{1'b0}}};
      end else if (go_rd_s || (state_r == ST_WB && ddr_ready && rd_after_wb_r)) begin
        ddr_addr_r    <= {tag_s, {LB{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_ninjin_ddr_linebuf.sv
// Directed bench for ninjin_ddr_linebuf (RATE=4): write combining, flush, read miss/fill,
// forwarding, write-back before read, auto-flush and mid-transfer reset.
module tb_ninjin_ddr_linebuf;

  logic               clk = 1'b0;
  logic               xrst;
  logic [9:0]         total_len;
  logic               flush, mem_req, mem_we;
  logic [11:0]        mem_addr;
  logic signed [15:0] mem_wdata;
  logic signed [15:0] mem_rdata;
  logic               mem_stall, done;
  logic               ddr_ready, ddr_rvalid;
  logic [63:0]        ddr_rdata;
  logic               ddr_we, ddr_re;
  logic [11:0]        ddr_addr;
  logic [63:0]        ddr_wdata;
  logic [3:0]         ddr_strb;

  int checks = 0;
  int failures = 0;

  ninjin_ddr_linebuf #(.DWIDTH(16), .BWIDTH(64), .MEMSIZE(12), .LWIDTH(10)) dut (
    .clk(clk), .xrst(xrst), .total_len(total_len), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .done(done),
    .ddr_ready(ddr_ready), .ddr_rvalid(ddr_rvalid), .ddr_rdata(ddr_rdata),
    .ddr_we(ddr_we), .ddr_re(ddr_re), .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_strb(ddr_strb)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    xrst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; flush = 1'b0;
    ddr_ready = 1'b0; ddr_rvalid = 1'b0; total_len = 10'd0;
    step;
    xrst = 1'b1;
  endtask

  // Write with stall handling; DDR accepts write-backs immediately while waiting
  task automatic do_wr(input logic [11:0] a, input logic [15:0] d);
    bit ok = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d; ddr_ready = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (!mem_stall) ok = 1'b1;
      step;
    end
    mem_req = 1'b0; ddr_ready = 1'b0;
    checks++;
    if (!ok) begin $display("FAIL wr_timeout addr=%0d got=stalled required=accepted", a); failures++; end
  endtask

  task automatic test_reset;
    xrst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; flush = 1'b0; mem_addr = 12'd0; mem_wdata = 16'sd0;
    ddr_ready = 1'b0; ddr_rvalid = 1'b0; ddr_rdata = 64'd0; total_len = 10'd0;
    step; #1;
    checks++;
    if ({mem_stall, done, ddr_we, ddr_re} !== 4'b0000) begin
      $display("FAIL reset_ctrl got=%b required=0000", {mem_stall, done, ddr_we, ddr_re}); failures++;
    end
    checks++;
    if (ddr_addr !== 12'd0 || ddr_strb !== 4'd0 || ddr_wdata !== 64'd0 || mem_rdata !== 16'sd0) begin
      $display("FAIL reset_data addr=%h strb=%h wdata=%h rdata=%h required=0", ddr_addr, ddr_strb, ddr_wdata, mem_rdata);
      failures++;
    end
    step;
    xrst = 1'b1;
  endtask

  task automatic test_write_combine;
    int nostall = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'(i); mem_wdata = 16'(i);
      #1;
      if (!mem_stall) nostall++;
      step;
    end
    checks++;
    if (nostall !== 4) begin $display("FAIL wc_nostall got=%0d required=4", nostall); failures++; end
    mem_addr = 12'd4; mem_wdata = 16'sd4;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin $display("FAIL wc_miss_stall got=%b required=1", mem_stall); failures++; end
    step; #1;
    checks++;
    if (ddr_we !== 1'b1 || ddr_addr !== 12'd0 || ddr_wdata !== 64'h0003_0002_0001_0000 || ddr_strb !== 4'hF) begin
      $display("FAIL wc_wb got we=%b addr=%h wdata=%h strb=%h required 1/000/0003000200010000/f",
               ddr_we, ddr_addr, ddr_wdata, ddr_strb); failures++;
    end
    step; #1;
    checks++;
    if (ddr_we !== 1'b1 || mem_stall !== 1'b1) begin
      $display("FAIL wc_wb_hold got we=%b stall=%b required=1/1", ddr_we, mem_stall); failures++;
    end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    #1;
    checks++;
    if (ddr_we !== 1'b0 || mem_stall !== 1'b0) begin
      $display("FAIL wc_after_wb got we=%b stall=%b required=0/0", ddr_we, mem_stall); failures++;
    end
    step;
    mem_req = 1'b0;
  endtask

  task automatic test_flush;
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    checks++;
    if (ddr_we !== 1'b1 || ddr_addr !== 12'd4 || ddr_strb !== 4'b0001) begin
      $display("FAIL fl_line4 got we=%b addr=%h strb=%b required=1/004/0001", ddr_we, ddr_addr, ddr_strb); failures++;
    end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin $display("FAIL fl_done got=%b required=1", done); failures++; end
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'd5; mem_wdata = 16'sd55;
    step;
    mem_req = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin $display("FAIL fl_done_pulse got=%b required=0", done); failures++; end
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    checks++;
    if (ddr_we !== 1'b1 || ddr_addr !== 12'd4 || ddr_strb !== 4'b0010 || ddr_wdata[31:16] !== 16'd55 || done !== 1'b0) begin
      $display("FAIL fl_partial got we=%b addr=%h strb=%b lane1=%0d done=%b required 1/004/0010/55/0",
               ddr_we, ddr_addr, ddr_strb, ddr_wdata[31:16], done); failures++;
    end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || ddr_we !== 1'b0) begin
      $display("FAIL fl_partial_done got done=%b we=%b required=1/0", done, ddr_we); failures++;
    end
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || ddr_we !== 1'b0) begin
      $display("FAIL fl_empty got done=%b we=%b required=1/0", done, ddr_we); failures++;
    end
    step;
  endtask

  task automatic test_read_miss;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'd9;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin $display("FAIL rd_miss_stall got=%b required=1", mem_stall); failures++; end
    step; #1;
    checks++;
    if (ddr_re !== 1'b1 || ddr_addr !== 12'd8 || ddr_we !== 1'b0) begin
      $display("FAIL rd_req got re=%b addr=%h we=%b required=1/008/0", ddr_re, ddr_addr, ddr_we); failures++;
    end
    step; #1;
    checks++;
    if (ddr_re !== 1'b1) begin $display("FAIL rd_req_hold got=%b required=1", ddr_re); failures++; end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (ddr_re !== 1'b0 || mem_stall !== 1'b1) begin
      $display("FAIL rd_wait got re=%b stall=%b required=0/1", ddr_re, mem_stall); failures++;
    end
    step;
    flush = 1'b0; ddr_rvalid = 1'b1; ddr_rdata = {16'd40, 16'd30, 16'd20, 16'd10};
    step;
    ddr_rvalid = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin $display("FAIL rd_fill_hit got stall=%b required=0", mem_stall); failures++; end
    step;
    mem_req = 1'b0;
    #1;
    checks++;
    if (mem_rdata !== 16'sd20 || done !== 1'b1) begin
      $display("FAIL rd_data got rdata=%0d done=%b required=20/1", mem_rdata, done); failures++;
    end
  endtask

  task automatic test_forward;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'd9; mem_wdata = 16'sd77;
    step;
    mem_we = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin $display("FAIL fwd_stall got=%b required=0", mem_stall); failures++; end
    step;
    mem_addr = 12'd10;
    #1;
    checks++;
    if (mem_rdata !== 16'sd77 || mem_stall !== 1'b0 || ddr_re !== 1'b0) begin
      $display("FAIL fwd_data got rdata=%0d stall=%b re=%b required=77/0/0", mem_rdata, mem_stall, ddr_re); failures++;
    end
    step;
    mem_req = 1'b0;
    #1;
    checks++;
    if (mem_rdata !== 16'sd30) begin $display("FAIL rline_hit got=%0d required=30", mem_rdata); failures++; end
  endtask

  task automatic test_read_wb;
    do_reset;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'd9; mem_wdata = 16'sd77;
    step;
    mem_we = 1'b0; mem_addr = 12'd10;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin $display("FAIL rwb_stall got=%b required=1", mem_stall); failures++; end
    step; #1;
    checks++;
    if (ddr_we !== 1'b1 || ddr_re !== 1'b0 || ddr_addr !== 12'd8 || ddr_strb !== 4'b0010) begin
      $display("FAIL rwb_wb got we=%b re=%b addr=%h strb=%b required=1/0/008/0010", ddr_we, ddr_re, ddr_addr, ddr_strb);
      failures++;
    end
    ddr_ready = 1'b1;
    step; #1;
    checks++;
    if (ddr_re !== 1'b1 || ddr_we !== 1'b0 || ddr_addr !== 12'd8) begin
      $display("FAIL rwb_rd got re=%b we=%b addr=%h required=1/0/008", ddr_re, ddr_we, ddr_addr); failures++;
    end
    step;
    ddr_ready = 1'b0; ddr_rvalid = 1'b1; ddr_rdata = {16'd40, 16'd30, 16'd77, 16'd10};
    step;
    ddr_rvalid = 1'b0;
    step;
    mem_req = 1'b0;
    #1;
    checks++;
    if (mem_rdata !== 16'sd30) begin $display("FAIL rwb_data got=%0d required=30", mem_rdata); failures++; end
  endtask

  task automatic test_auto_flush;
    do_reset;
    total_len = 10'd6;
    for (int i = 0; i < 6; i++) do_wr(12'(i), 16'(100 + i));
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ddr_we !== 1'b1 || ddr_addr !== 12'd4 || ddr_strb !== 4'b0011 || done !== 1'b0) begin
        $display("FAIL af_hold%0d got we=%b addr=%h strb=%b done=%b required=1/004/0011/0",
                 c, ddr_we, ddr_addr, ddr_strb, done); failures++;
      end
      step;
    end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || ddr_we !== 1'b0) begin
      $display("FAIL af_done got done=%b we=%b required=1/0", done, ddr_we); failures++;
    end
    for (int i = 16; i < 22; i++) do_wr(12'(i), 16'(i));
    #1;
    checks++;
    if (ddr_we !== 1'b1 || ddr_addr !== 12'd20 || ddr_strb !== 4'b0011) begin
      $display("FAIL af_wcnt_restart got we=%b addr=%h strb=%b required=1/014/0011", ddr_we, ddr_addr, ddr_strb);
      failures++;
    end
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin $display("FAIL af_done2 got=%b required=1", done); failures++; end
    total_len = 10'd0;
  endtask

  task automatic test_reset_midread;
    do_reset;
    ddr_rvalid = 1'b1; ddr_rdata = {16'd4, 16'd3, 16'd2, 16'd1};
    step;
    ddr_rvalid = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'd9;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin $display("FAIL stray_rvalid got stall=%b required=1", mem_stall); failures++; end
    step;
    ddr_ready = 1'b1;
    step;
    ddr_ready = 1'b0;
    xrst = 1'b0; mem_req = 1'b0;
    #1;
    checks++;
    if (ddr_re !== 1'b0 || mem_stall !== 1'b0 || ddr_addr !== 12'd0) begin
      $display("FAIL rst_mid got re=%b stall=%b addr=%h required=0/0/000", ddr_re, mem_stall, ddr_addr); failures++;
    end
    step;
    xrst = 1'b1; mem_req = 1'b1;
    step; #1;
    checks++;
    if (ddr_re !== 1'b1 || ddr_addr !== 12'd8) begin
      $display("FAIL rst_reissue got re=%b addr=%h required=1/008", ddr_re, ddr_addr); failures++;
    end
    mem_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write_combine;
    test_flush;
    test_read_miss;
    test_forward;
    test_read_wb;
    test_auto_flush;
    test_reset_midread;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
